// File: rtl/flash_read_responder_if.sv
// Avalon-MM read-slave bundle for flash_read_responder: request, waitrequest and read-return signals.
interface flash_read_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic [3:0]        avs_byteenable;
    logic              avs_waitrequest;
    logic [31:0]       avs_readdata;
    logic              avs_readdatavalid;

    modport master (
        output avs_address,
        output avs_read,
        output avs_byteenable,
        input  avs_waitrequest,
        input  avs_readdata,
        input  avs_readdatavalid
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_byteenable,
        output avs_waitrequest,
        output avs_readdata,
        output avs_readdatavalid
    );
endinterface

// File: rtl/flash_read_responder.sv
// Flash-substitute Avalon-MM read slave: fixed-latency, bounded-outstanding reads from a loadable word array.
// Optional FLASH_RESP_RANDWAIT_EN adds LFSR-driven random waitrequest for masters that hold read.
module flash_read_responder #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned READ_LATENCY = 3,
    parameter int unsigned MAX_PENDING  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    flash_read_responder_if.slave avs,
    input  logic                 ld_we,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [31:0]          ld_data
);
    localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

    logic [31:0]             mem [2**ADDR_W];
    logic [READ_LATENCY-1:0] pipe_v;
    logic [31:0]             pipe_d [READ_LATENCY];
    logic [READ_LATENCY-1:0] in_v;
    logic [31:0]             in_d [READ_LATENCY];
    logic [CNT_W-1:0]        pending;
    logic [31:0]             rd_word;
    logic [31:0]             masked;
    logic                    accept;
    logic                    ret;
    logic                    full;
    logic                    rand_stall;
    logic                    wait_req;

    // Array holds contents across reset; a same-edge load is seen only by later reads.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        rd_word = mem[avs.avs_address];
        masked  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            masked[8*i +: 8] = avs.avs_byteenable[i] ? rd_word[8*i +: 8] : 8'h00;
        end
    end

`ifdef FLASH_RESP_RANDWAIT_EN
    logic [7:0] lfsr;

    // x^8+x^6+x^5+x^4+1, Fibonacci form
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign rand_stall = lfsr[0] & avs.avs_read;
`else
    assign rand_stall = 1'b0;
`endif

    assign ret      = pipe_v[READ_LATENCY-1];
    assign full     = (pending == CNT_W'(MAX_PENDING));
    assign wait_req = (full && !ret) || rand_stall;
    assign accept   = avs.avs_read && !wait_req;

    // The last pipeline stage doubles as the output register, so readdata holds between returns.
    always_comb begin
        in_v    = '0;
        for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            in_d[i] = '0;
        end
        in_v[0] = accept;
        in_d[0] = masked;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            in_v[i] = pipe_v[i-1];
            in_d[i] = pipe_d[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v <= in_v;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                if (in_v[i]) begin
                    pipe_d[i] <= in_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            case ({accept, ret})
                2'b10:   pending <= pending + CNT_W'(1);
                2'b01:   pending <= pending - CNT_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    assign avs.avs_waitrequest   = wait_req;
    assign avs.avs_readdatavalid = ret;
    assign avs.avs_readdata      = pipe_d[READ_LATENCY-1];
endmodule

// File: tb/tb_flash_read_responder.sv
// Scoreboard bench for flash_read_responder: driver pushes expected words, negedge monitor pops and compares.
module tb_flash_read_responder;
    localparam int unsigned AW   = 8;
    localparam int unsigned LAT  = 3;
    localparam int unsigned MAXP = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] model [256];
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          returns = 0;
    int          ret0;
    bit          saw_wait;

    always #5 clk = ~clk;

    flash_read_responder_if #(.ADDR_W(AW)) avs_bus ();

    flash_read_responder #(
        .ADDR_W      (AW),
        .READ_LATENCY(LAT),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .avs    (avs_bus.slave),
        .ld_we  (ld_we),
        .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mask(input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = w[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] pat(input logic [7:0] i);
        return {i, 8'h5A, ~i, i};
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1 && avs_bus.avs_readdatavalid === 1'b1) begin
            returns++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdv: readdata %h with no read outstanding", avs_bus.avs_readdata);
            end else begin
                mon_e = q.pop_front();
                check("rd_data", avs_bus.avs_readdata, mon_e.data);
                check("rd_latency", cyc - mon_e.cyc, LAT);
            end
        end
    end

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        #1;
        ld_we    = 1'b0;
        model[a] = d;
    endtask

    // Holds read until accepted; with collide, a load to the same address lands on the accept edge.
    task automatic do_read(input logic [7:0] a, input logic [3:0] be, input logic [31:0] exp_data,
                           input bit collide, input logic [31:0] new_data);
        bit   done;
        exp_t e;
        done = 0;
        avs_bus.avs_address    = a;
        avs_bus.avs_byteenable = be;
        avs_bus.avs_read       = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (avs_bus.avs_waitrequest === 1'b0) begin
                e.data = exp_data;
                e.cyc  = cyc;
                q.push_back(e);
                done = 1;
                if (collide) begin
                    ld_we   = 1'b1;
                    ld_addr = a;
                    ld_data = new_data;
                end
            end else begin
                saw_wait = 1;
            end
            @(posedge clk);
            #1;
        end
        if (collide && done) begin
            ld_we    = 1'b0;
            model[a] = new_data;
        end
        avs_bus.avs_read = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: addr %h waitrequest stuck at 1, expected 0 within 100 cycles", a);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && q.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000 ns, expected to finish");
        $fatal(1);
    end

    initial begin
        rst                    = 1'b0;
        ld_we                  = 1'b0;
        ld_addr                = '0;
        ld_data                = '0;
        avs_bus.avs_read       = 1'b0;
        avs_bus.avs_address    = '0;
        avs_bus.avs_byteenable = '0;
        #2;
        check("reset_waitrequest", avs_bus.avs_waitrequest, 0);
        check("reset_rdv", avs_bus.avs_readdatavalid, 0);
        check("reset_readdata", avs_bus.avs_readdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 256; i++) load(8'(i), pat(8'(i)));
        load(8'h10, 32'hBEEF_1234);
        load(8'h20, 32'h0000_0001);

        // single-cycle read, latency and hold
        saw_wait = 0;
        do_read(8'h10, 4'hF, 32'hBEEF_1234, 0, '0);
        repeat (LAT + 1) begin
            @(negedge clk);
            if (avs_bus.avs_waitrequest !== 1'b0) saw_wait = 1;
        end
`ifndef FLASH_RESP_RANDWAIT_EN
        check("t1_waitrequest_low", saw_wait, 0);
`endif
        check("t1_rdv_after", avs_bus.avs_readdatavalid, 0);
        check("t1_readdata_hold", avs_bus.avs_readdata, 32'hBEEF_1234);
        @(posedge clk);
        #1;

        // byte-lane masking
        do_read(8'h10, 4'b0011, 32'h0000_1234, 0, '0);
        do_read(8'h10, 4'b1100, 32'hBEEF_0000, 0, '0);
        do_read(8'h10, 4'b0000, 32'h0000_0000, 0, '0);
        do_read(8'h10, 4'b0101, 32'h00EF_0034, 0, '0);
        drain();

        // read held across four addresses: pending limit must stall
        saw_wait = 0;
        ret0     = returns;
        for (int i = 0; i < 4; i++) do_read(8'(i), 4'hF, pat(8'(i)), 0, '0);
        drain();
`ifndef FLASH_RESP_RANDWAIT_EN
        check("t3_waitrequest_seen", saw_wait, 1);
`endif
        check("t3_return_count", returns - ret0, 4);

        // load/read collision returns the old word
        do_read(8'h20, 4'hF, 32'h0000_0001, 1, 32'h0000_0002);
        do_read(8'h20, 4'hF, 32'h0000_0002, 0, '0);
        drain();

        // reset with two reads in flight
        do_read(8'h10, 4'hF, 32'hBEEF_1234, 0, '0);
        do_read(8'h11, 4'hF, pat(8'h11), 0, '0);
        rst = 1'b0;
        q.delete();
        #1;
        check("t5_rst_waitrequest", avs_bus.avs_waitrequest, 0);
        check("t5_rst_rdv", avs_bus.avs_readdatavalid, 0);
        check("t5_rst_readdata", avs_bus.avs_readdata, 0);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ret0 = returns;
        repeat (LAT + 3) @(negedge clk);
        check("t5_no_stale_returns", returns - ret0, 0);
        check("t5_waitrequest_after", avs_bus.avs_waitrequest, 0);
        @(posedge clk);
        #1;
        do_read(8'h10, 4'hF, 32'hBEEF_1234, 0, '0);
        do_read(8'h20, 4'hF, 32'h0000_0002, 0, '0);
        drain();

`ifdef FLASH_RESP_RANDWAIT_EN
        saw_wait = 0;
        for (int i = 0; i < 200; i++) begin
            logic [7:0] a;
            logic [3:0] be;
            a  = 8'($urandom_range(0, 255));
            be = 4'($urandom_range(0, 15));
            do_read(a, be, mask(model[a], be), 0, '0);
        end
        drain();
        check("t6_waitrequest_seen", saw_wait, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
